// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: instruction/byte/address widths and fetch FSM states.
package cpu_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned PC_STEP = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_CAP,
    S_VALID,
    S_FAULT
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_ctrl.sv
// Fetches 16-bit big-endian instructions as two byte reads and hands them to decode.
// Optional FETCH_BOUND_CHECK_EN: out-of-range fetches enter a sticky fault state.
module instruction_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W    = cpu_pkg::ADDR_W,
  parameter int unsigned       MEM_DEPTH = 128,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd_en,
  input  logic [BYTE_W-1:0]  mem_rd_data,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               fault
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [BYTE_W-1:0]  hi_q, hi_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               valid_q, valid_d;
  logic               fault_q, fault_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               rd_en_q, rd_en_d;
  logic               oob_d;

  // The high-byte read of the next PC is suppressed when PC+1 falls outside memory.
`ifdef FETCH_BOUND_CHECK_EN
  assign oob_d = ({1'b0, pc_d} + (ADDR_W+1)'(1)) >= (ADDR_W+1)'(MEM_DEPTH);
`else
  logic unused_cfg;
  assign oob_d      = 1'b0;
  assign unused_cfg = (MEM_DEPTH == 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      hi_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hi_q       <= hi_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      addr_q     <= addr_d;
      rd_en_q    <= rd_en_d;
    end
  end

  // Next-state logic; redirect overrides every state and discards reads in flight.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hi_d       = hi_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    if (redirect) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      fault_d = 1'b0;
      state_d = halt ? S_IDLE : S_HI;
    end else begin
      unique case (state_q)
        S_IDLE: if (!halt) state_d = S_HI;
        S_HI: begin
`ifdef FETCH_BOUND_CHECK_EN
          if (!rd_en_q) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end else begin
            state_d = S_LO;
          end
`else
          state_d = S_LO;
`endif
        end
        S_LO: begin
          hi_d    = mem_rd_data;
          state_d = S_CAP;
        end
        S_CAP: begin
          instr_d    = {hi_q, mem_rd_data};
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          state_d    = S_VALID;
        end
        S_VALID: begin
          if (instr_ready) begin
            valid_d = 1'b0;
            pc_d    = pc_q + ADDR_W'(PC_STEP);
            state_d = halt ? S_IDLE : S_HI;
          end
        end
`ifdef FETCH_BOUND_CHECK_EN
        S_FAULT: state_d = S_FAULT;
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Memory strobe/address registered from the state being entered next cycle.
  always_comb begin
    rd_en_d = 1'b0;
    addr_d  = '0;
    if (state_d == S_HI) begin
      rd_en_d = !oob_d;
      addr_d  = pc_d;
    end else if (state_d == S_LO) begin
      rd_en_d = 1'b1;
      addr_d  = pc_d + ADDR_W'(1);
    end
  end

  assign mem_addr    = addr_q;
  assign mem_rd_en   = rd_en_q;
  assign instr_valid = valid_q;
  assign instruction = instr_q;
  assign instr_pc    = instr_pc_q;
`ifdef FETCH_BOUND_CHECK_EN
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Scoreboard bench for instruction_fetch_ctrl: directed scenarios then randomized redirect/halt/ready traffic.
module tb_instruction_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instruction;
  logic [15:0] instr_pc;
  logic        fault;

  always #5 clk = ~clk;

  instruction_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rd_data(mem_rd_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc), .fault(fault)
  );

  // Byte memory with one-cycle read latency; junk on the bus when not reading.
  logic [7:0] mem [0:127];
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_addr[6:0]] : 8'($urandom);

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    bit          is_fault;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          fails = 0;
  int          presents = 0;

  function automatic logic [15:0] ref_instr(input logic [15:0] pc);
    logic [15:0] nxt;
    nxt = pc + 16'd1;
    return {mem[pc[6:0]], mem[nxt[6:0]]};
  endfunction

  function automatic void push_exp(input logic [15:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = ref_instr(pc);
`ifdef FETCH_BOUND_CHECK_EN
    e.is_fault = (17'(pc) + 17'd1) >= 17'd128;
`else
    e.is_fault = 1'b0;
`endif
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the program order is pc, pc+2, ... restarted at every redirect target.
  logic [15:0] model_pc;
  task automatic step(input bit rd, input logic [15:0] tgt, input bit rdy, input bit hlt);
    redirect    = rd;
    redirect_pc = tgt;
    instr_ready = rdy;
    halt        = hlt;
    if (rd) begin
      exp_q.delete();
      push_exp(tgt);
      model_pc = tgt;
    end else if (instr_valid && rdy) begin
      model_pc = model_pc + 16'd2;
      push_exp(model_pc);
    end
    @(negedge clk);
  endtask

  // Monitor: pops an expectation on each new presentation or fault, and checks holds stay stable.
  initial begin
    logic        lv, lf;
    logic [15:0] held_i, held_pc;
    exp_t        e;
    lv = 1'b0; lf = 1'b0; held_i = '0; held_pc = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        lv = 1'b0; lf = 1'b0;
        continue;
      end
      if (instr_valid && !lv) begin
        presents++;
        if (exp_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_instr: got pc %0h with nothing expected", instr_pc);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", 32'(instr_pc), 32'(e.pc));
          check("instruction", 32'(instruction), 32'(e.instr));
          check("instr_where_fault_due", 32'(e.is_fault), 32'd0);
        end
        held_i = instruction; held_pc = instr_pc;
      end else if (instr_valid && lv) begin
        check("hold_instruction", 32'(instruction), 32'(held_i));
        check("hold_instr_pc", 32'(instr_pc), 32'(held_pc));
      end
      if (fault && !lf) begin
        if (exp_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_fault: got fault 1 with nothing expected");
        end else begin
          e = exp_q.pop_front();
          check("fault_due", 32'(e.is_fault), 32'd1);
        end
      end
      lv = instr_valid;
      lf = fault;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          hlt;
    logic [15:0] tgt;
    int          p0;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0; instr_ready = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
    push_exp(16'h0000);
    model_pc = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_instruction", 32'(instruction), 0);
    check("rst_instr_pc", 32'(instr_pc), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_rd_en", 32'(mem_rd_en), 0);
    check("rst_addr", 32'(mem_addr), 0);

    // Basic fetch, latency and stall.
    rst_n = 1'b1;
    check("idle_rd_en", 32'(mem_rd_en), 0);
    step(0, 0, 0, 0);
    check("hi_rd_en", 32'(mem_rd_en), 1);
    check("hi_addr", 32'(mem_addr), 0);
    step(0, 0, 0, 0);
    check("lo_addr", 32'(mem_addr), 1);
    step(0, 0, 0, 0);
    check("cap_valid", 32'(instr_valid), 0);
    step(0, 0, 0, 0);
    check("lat_valid", 32'(instr_valid), 1);
    check("first_instr", 32'(instruction), 32'h1234);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      check("stall_rd_en", 32'(mem_rd_en), 0);
      check("stall_valid", 32'(instr_valid), 1);
    end
    step(0, 0, 1, 0);
    check("next_addr", 32'(mem_addr), 2);
    check("next_valid", 32'(instr_valid), 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("thru_valid_lo", 32'(instr_valid), 0);
    step(0, 0, 0, 0);
    check("thru_valid", 32'(instr_valid), 1);
    check("second_instr", 32'(instruction), 32'h5678);

    // Redirect while the low byte is in flight.
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check("lo_addr_pc4", 32'(mem_addr), 5);
    step(1, 16'h0041, 0, 0);
    check("redir_addr", 32'(mem_addr), 32'h41);
    repeat (3) step(0, 0, 0, 0);
    check("redir_valid", 32'(instr_valid), 1);
    check("redir_pc", 32'(instr_pc), 32'h41);

    // Halt raised mid-fetch: instruction completes, then no reads until released.
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("halt_valid", 32'(instr_valid), 1);
    step(0, 0, 1, 1);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1);
      check("halt_rd_en", 32'(mem_rd_en), 0);
    end
    step(0, 0, 0, 0);
    check("unhalt_addr", 32'(mem_addr), 32'h45);
    check("unhalt_rd_en", 32'(mem_rd_en), 1);

    // Top of memory.
    step(1, 16'h007F, 0, 0);
`ifdef FETCH_BOUND_CHECK_EN
    check("oob_rd_en", 32'(mem_rd_en), 0);
    step(0, 0, 0, 0);
    check("oob_fault", 32'(fault), 1);
    check("oob_rd_en2", 32'(mem_rd_en), 0);
    step(0, 0, 1, 0);
    check("fault_sticky", 32'(fault), 1);
    check("fault_valid", 32'(instr_valid), 0);
    step(1, 16'h0000, 0, 0);
    check("fault_clear", 32'(fault), 0);
    check("resume_rd_en", 32'(mem_rd_en), 1);
    check("resume_addr", 32'(mem_addr), 0);
`else
    check("edge_addr_hi", 32'(mem_addr), 32'h7F);
    step(0, 0, 0, 0);
    check("edge_addr_lo", 32'(mem_addr), 32'h80);
    repeat (2) step(0, 0, 0, 0);
    step(1, 16'hFFFF, 0, 0);
    check("wrap_addr_hi", 32'(mem_addr), 32'hFFFF);
    step(0, 0, 0, 0);
    check("wrap_addr_lo", 32'(mem_addr), 32'h0000);
    check("wrap_fault", 32'(fault), 0);
    repeat (2) step(0, 0, 0, 0);
`endif

    // Reset asserted during capture.
    step(1, 16'h0010, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(instr_valid), 0);
    check("midrst_instruction", 32'(instruction), 0);
    check("midrst_instr_pc", 32'(instr_pc), 0);
    check("midrst_rd_en", 32'(mem_rd_en), 0);
    exp_q.delete();
    push_exp(16'h0000);
    model_pc = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_idle", 32'(mem_rd_en), 0);
    step(0, 0, 0, 0);
    check("post_rst_rd_en", 32'(mem_rd_en), 1);
    check("post_rst_addr", 32'(mem_addr), 32'(16'h0000));

    // Randomized traffic.
    p0 = presents;
    hlt = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) hlt = !hlt;
      case ($urandom_range(3))
        0, 1:    tgt = 16'($urandom_range(127));
        2:       tgt = 16'hFFF0 + 16'($urandom_range(15));
        default: tgt = 16'($urandom);
      endcase
      step($urandom_range(11) == 0, tgt, $urandom_range(9) < 7, hlt);
    end
    check("progress", 32'(presents - p0 > 50), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_ctrl.md
Name: instruction_fetch_ctrl

Overview:
- Sequences the byte-wide, byte-addressed instruction memory to deliver 16-bit big-endian instructions: high byte at PC, low byte at PC+1.
- Owns the program counter and issues two synchronous byte reads per instruction.
- Assembles the instruction and hands it to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute.

Parameters:
- ADDR_W, 16, width of PC and memory address.
- MEM_DEPTH, 128, instruction memory size in bytes.
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- Clock  input  1  single system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- MemAddr  output  ADDR_W  byte address to instruction memory.
- MemRdEn  output  1  read strobe; read data returns on MemRdData one cycle later.
- MemRdData  input  8  byte returned for the read issued the previous cycle.
- Redirect  input  1  one-cycle pulse: load RedirectPC and restart fetch.
- RedirectPC  input  ADDR_W  target address.
- Halt  input  1  level; stops new fetches.
- InstrValid  output  1  Instruction/InstrPC hold a valid instruction.
- InstrReady  input  1  decode accepts the instruction.
- Instruction  output  16  {byte[PC], byte[PC+1]}.
- InstrPC  output  ADDR_W  address of the high byte of Instruction.
- Fault  output  1  sticky out-of-range fetch flag; driven only with the optional feature, else tied 0.

Behaviour:
- Reset (async assert, Reset_n low):
  - PC=RESET_PC, state=S_IDLE.
  - InstrValid=0, Instruction=0, InstrPC=0, Fault=0.
  - MemRdEn=0, MemAddr=0.
- Outputs: all outputs are registered or decoded from state only. No combinational path from InstrReady or Redirect to any output.
- States:
  - S_IDLE: MemRdEn=0. Goes to S_HI when Halt=0, otherwise stays.
  - S_HI: MemAddr=PC, MemRdEn=1. Goes to S_LO.
  - S_LO: MemAddr=PC+1 (ADDR_W-bit add), MemRdEn=1. Captures hi byte from MemRdData. Goes to S_CAP.
  - S_CAP: MemRdEn=0. Registers Instruction={hi, MemRdData}, InstrPC=PC, InstrValid=1 for the next cycle. Goes to S_VALID.
  - S_VALID: holds Instruction/InstrPC stable while InstrValid=1 and InstrReady=0. When InstrReady=1: InstrValid=0, PC=PC+2, then S_IDLE if Halt=1, else S_HI.
- Latency: 3 cycles from S_HI entry to InstrValid=1. Maximum throughput is 1 instruction per 4 cycles.
- Redirect has highest priority in every state:
  - Next cycle: PC=RedirectPC, InstrValid=0, state=S_HI (S_IDLE if Halt=1).
  - Any read in flight is discarded; its returned byte is ignored.
  - Redirect together with InstrReady in S_VALID: the instruction counts as consumed, and PC takes RedirectPC, not PC+2.
- Halt:
  - Sampled only in S_IDLE and at S_VALID exit.
  - An in-progress fetch always completes and is presented.
  - Redirect while halted updates PC, then stays in S_IDLE.
- Odd addresses: RedirectPC may be odd and is fetched as-is; no alignment is enforced.
- Wrap-around: PC and PC+1 wrap modulo 2^ADDR_W, e.g. PC=16'hFFFF reads FFFF then 0000. MemAddr carries the full ADDR_W bits; memory decodes the low bits.

Optional Feature:
- Macro: FETCH_BOUND_CHECK_EN.
- Defined:
  - In S_HI, if PC+1 >= MEM_DEPTH, no read is issued (MemRdEn=0) and the block enters S_FAULT.
  - In S_FAULT: Fault=1, InstrValid=0, MemRdEn=0.
  - Leaves S_FAULT only on Redirect, which clears Fault (next state S_HI), or on reset.
- Undefined: no S_FAULT state, Fault tied 0, addresses wrap as above.

Decomposition:
- Shared package cpu_pkg:
  - INSTR_W=16, BYTE_W=8, ADDR_W default.
  - Fetch state enum (S_IDLE, S_HI, S_LO, S_CAP, S_VALID, S_FAULT).
  - PC_STEP=2.
- Single module; no sub-module. The PC register/incrementer stays inline.

Test Plan:
- Reset, memory bytes 0x12,0x34,0x56,0x78 at 0..3, InstrReady=1 -> Instruction=16'h1234, InstrPC=0, valid 3 cycles after first S_HI; next Instruction=16'h5678, InstrPC=2, 4 cycles later.
- InstrReady held 0 for 5 cycles with valid 16'h1234 -> output stable, MemRdEn=0 throughout, PC stays 0. Release -> next fetch from 2.
- Redirect to 16'h0041 during S_LO -> in-flight byte dropped, InstrValid never asserted for the old PC, next Instruction = {mem[0x41], mem[0x42]} with InstrPC=16'h0041.
- Halt=1 during S_LO -> current instruction still delivered. After the handshake, MemRdEn stays 0 until Halt=0.
- PC=16'h007F: without the macro, reads addresses 7F then 80. With FETCH_BOUND_CHECK_EN, Fault=1 and no read; Redirect to 0 clears Fault and fetching resumes.
- Reset_n asserted mid S_CAP -> immediately InstrValid=0, Instruction=0, PC=RESET_PC. First read issued 2 cycles after deassertion (S_IDLE then S_HI).
